ahb_ram_slave: RTL and testbench
================================

AHB_RAM_SLAVE -- requirements
Module: ahb_ram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 0 (range 0-15), meaning wait cycles inserted per data phase.
REQ-003 SHALL have port HCLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port HSEL, input, 1, meaning the decoder select for this slave.
REQ-006 SHALL have port HADDR, input, 32, meaning the byte address.
REQ-007 SHALL have port HTRANS, input, 2, meaning the transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 SHALL have port HWRITE, input, 1, meaning 1 = write, 0 = read.
REQ-009 SHALL have port HSIZE, input, 3, meaning 0 = byte, 1 = half-word, 2 = word.
REQ-010 SHALL have port HWDATA, input, 32, meaning write data, valid in the data phase.
REQ-011 SHALL have port HREADY, input, 1, meaning the bus-wide ready returned by the response mux.
REQ-012 SHALL have port HREADYOUT, output, 1, meaning this slave's ready, routed to the mux RAM_HREADY input.
REQ-013 SHALL have port HRESP, output, 1, meaning 0 = OKAY, 1 = ERROR, routed to RAM_HRESP.
REQ-014 SHALL have port HRDATA, output, 32, meaning read data, routed to RAM_HRDATA.

Function
REQ-015 SHALL accept an address phase only on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; IDLE, BUSY or HSEL=0 transfers get a zero-wait OKAY response with no side effect.
REQ-016 SHALL register HADDR, HWRITE and HSIZE at acceptance, and SHALL use only these registered values during the data phase.
REQ-017 SHALL flag an access as erroneous when any of the following holds: HADDR[31:2] >= MEM_DEPTH; HSIZE > 2; a half-word access with HADDR[0] != 0; a word access with HADDR[1:0] != 0.
REQ-018 SHALL implement an FSM with states IDLE, WAIT, ERR1 and ERR2.
REQ-019 On a valid access, SHALL enter WAIT if WAIT_STATES > 0, otherwise complete in the following cycle with HREADYOUT=1 and HRESP=0.
REQ-020 In WAIT, SHALL drive HREADYOUT=0 and HRESP=0 for exactly WAIT_STATES cycles using a 4-bit down-counter, then drive HREADYOUT=1 for one cycle.
REQ-021 On an erroneous access, SHALL go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE; it SHALL NOT insert wait states before ERR1.
REQ-022 SHALL write memory on the data-phase completion edge (HREADYOUT=1), using HWDATA and byte lanes selected by the registered HSIZE and HADDR[1:0]; unselected bytes SHALL remain unchanged.
REQ-023 SHALL NOT modify memory on an erroneous write.
REQ-024 SHALL drive HRDATA with the full addressed word while a read data phase is completing; at all other times HRDATA SHALL be 32'h0.
REQ-025 SHALL accept a new address phase in the same cycle a data phase completes, giving back-to-back transfers with no idle cycle.
REQ-026 A read that directly follows a write to the same word SHALL return the newly written data.
REQ-027 In ERR2, SHALL accept a new address phase only if the master has not driven HTRANS=IDLE; both cases SHALL be handled correctly.

Reset
REQ-028 Assertion of HRESETn=0 SHALL immediately set state=IDLE, counter=0, HREADYOUT=1, HRESP=0 and HRDATA=32'h0, including mid-transfer.
REQ-029 Memory contents SHALL NOT be reset; any in-flight write at reset assertion SHALL be discarded.

Verification
REQ-030 Bench SHALL cover, with WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read data phase has HREADYOUT=1 and HRDATA=0xDEADBEEF.
REQ-031 Bench SHALL cover, with WAIT_STATES=3: read 0x04 -> HREADYOUT low for exactly 3 cycles, then high with the correct data.
REQ-032 Bench SHALL cover: byte write 0xAA to 0x13 over word 0x11223344 -> a read of 0x10 returns 0xAA223344.
REQ-033 Bench SHALL cover: access to 0x400 with MEM_DEPTH=256, and a word access to 0x02 -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1), memory unchanged.
REQ-034 Bench SHALL cover: HRESETn pulsed low during WAIT -> outputs return to their reset values asynchronously, and the next transfer completes normally.
REQ-035 Bench SHALL cover: HTRANS=BUSY or HSEL=0 -> HREADYOUT=1, HRESP=0, no memory write.

Source files
------------

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite signal bundle between the bus fabric and the RAM slave.
// HREADY is the bus-wide ready returned by the response mux.
interface ahb_ram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_ram_slave.sv
// AHB-Lite word-organised RAM slave with configurable wait states and a
// two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_ram_slave #(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   ahb_ram_slave_if.slave  bus
);

   localparam int         AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t        state_q, state_n;
   logic [3:0]    cnt_q, cnt_n;
   logic          pending_q, pending_n;
   logic [AW+1:0] addr_q;
   logic          write_q;
   logic [1:0]    size_q;

   logic [31:0]   mem [MEM_DEPTH];

   logic          hready_out;
   logic          accept;
   logic          addr_err;
   logic          complete;
   logic [3:0]    lane_en;
   logic [AW-1:0] word_idx;
   logic          unused_trans;

   // Only IDLE and ERR2 present HREADYOUT high, so only they can take a new address phase.
   assign hready_out   = (state_q == IDLE) || (state_q == ERR2);
   assign accept       = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hready_out;
   assign complete     = (state_q == IDLE) && pending_q;
   assign word_idx     = addr_q[AW+1:2];
   assign unused_trans = bus.HTRANS[0];

   assign bus.HREADYOUT = hready_out;
   assign bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
   assign bus.HRDATA    = (complete && !write_q) ? mem[word_idx] : 32'h0;

   always_comb begin
      addr_err = 1'b0;
      if ({2'b00, bus.HADDR[31:2]} >= 32'(MEM_DEPTH)) addr_err = 1'b1;
      if (bus.HSIZE > 3'd2) addr_err = 1'b1;
      if ((bus.HSIZE == 3'd1) && bus.HADDR[0]) addr_err = 1'b1;
      if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) addr_err = 1'b1;
   end

   always_comb begin
      lane_en = 4'b0000;
      case (size_q)
         2'd0:    lane_en[addr_q[1:0]] = 1'b1;
         2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      pending_n = pending_q;
      case (state_q)
         IDLE, ERR2: begin
            state_n   = IDLE;
            pending_n = 1'b0;
            if (accept) begin
               if (addr_err) begin
                  state_n = ERR1;
               end else begin
                  pending_n = 1'b1;
                  if (WS != 4'd0) begin
                     state_n = WAIT;
                     cnt_n   = WS;
                  end
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt_q - 4'd1;
            end
         end
         ERR1:    state_n = ERR2;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         pending_q <= 1'b0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         size_q    <= 2'd0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         pending_q <= pending_n;
         if (accept) begin
            addr_q  <= bus.HADDR[AW+1:0];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE[1:0];
         end
      end
   end

   // Memory is deliberately unreset; clearing pending_q on reset drops any in-flight write.
   always_ff @(posedge HCLK) begin
      if (complete && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench for ahb_ram_slave: a pipelined AHB driver issues random and
// directed transfers to a zero-wait and a three-wait instance, a monitor checks responses.
module tb_ahb_ram_slave;

   localparam int DEPTH = 256;
   localparam int WS1   = 3;
   localparam int GUARD = 4000;

   typedef enum int {K_XFER, K_IDLE, K_BUSY, K_UNSEL} kind_t;

   typedef struct {
      kind_t       kind;
      bit          write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      bit          err;
      bit          read;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb_ram_slave_if bus0();
   ahb_ram_slave_if bus1();

   ahb_ram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESETn(rst_n), .bus(bus0.slave)
   );
   ahb_ram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
      .HCLK(clk), .HRESETn(rst_n), .bus(bus1.slave)
   );

   logic        m_sel;
   logic [31:0] m_addr;
   logic [1:0]  m_trans;
   logic        m_write;
   logic [2:0]  m_size;
   logic [31:0] m_wdata;
   logic        dut_sel;

   // Only the instance picked by dut_sel sees HSEL; each instance is alone on its own bus.
   assign bus0.HSEL   = m_sel && !dut_sel;
   assign bus1.HSEL   = m_sel && dut_sel;
   assign bus0.HADDR  = m_addr;
   assign bus1.HADDR  = m_addr;
   assign bus0.HTRANS = m_trans;
   assign bus1.HTRANS = m_trans;
   assign bus0.HWRITE = m_write;
   assign bus1.HWRITE = m_write;
   assign bus0.HSIZE  = m_size;
   assign bus1.HSIZE  = m_size;
   assign bus0.HWDATA = m_wdata;
   assign bus1.HWDATA = m_wdata;
   assign bus0.HREADY = bus0.HREADYOUT;
   assign bus1.HREADY = bus1.HREADYOUT;

   wire        cur_ready = dut_sel ? bus1.HREADYOUT : bus0.HREADYOUT;
   wire        cur_resp  = dut_sel ? bus1.HRESP : bus0.HRESP;
   wire [31:0] cur_rdata = dut_sel ? bus1.HRDATA : bus0.HRDATA;

   int          total;
   int          bad;
   bit          mon_en;
   op_t         ops[$];
   exp_t        exp_q[$];
   logic [31:0] model_mem [2][DEPTH];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit expectErr(input logic [31:0] a, input logic [2:0] s);
      int unsigned nbytes;
      if ((a / 4) >= DEPTH) return 1'b1;
      if (s > 3'd2) return 1'b1;
      nbytes = 1 << s;
      return (a % nbytes) != 0;
   endfunction

   // Reference model: byte-addressed little-endian RAM, lane = byte address mod 4.
   task automatic pushExpected(input op_t o);
      exp_t        e;
      int unsigned nbytes;
      int unsigned ba;
      e.err   = expectErr(o.addr, o.size);
      e.read  = !o.write;
      e.rdata = 32'h0;
      if (!e.err) begin
         if (o.write) begin
            nbytes = 1 << o.size;
            for (int k = 0; k < int'(nbytes); k++) begin
               ba = o.addr + k;
               model_mem[dut_sel][ba / 4][8*(ba % 4) +: 8] = o.wdata[8*(ba % 4) +: 8];
            end
         end else begin
            e.rdata = model_mem[dut_sel][o.addr / 4];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic addOp(input kind_t k, input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      op_t o;
      o.kind = k; o.write = w; o.addr = a; o.size = s; o.wdata = d;
      ops.push_back(o);
   endtask

   function automatic op_t randomOp();
      op_t o;
      int  r;
      r = $urandom_range(0, 9);
      if (r < 7)       o.kind = K_XFER;
      else if (r == 7) o.kind = K_IDLE;
      else if (r == 8) o.kind = K_BUSY;
      else             o.kind = K_UNSEL;
      o.write = 1'($urandom_range(0, 1));
      o.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      o.addr  = 32'($urandom_range(0, 63));
      if (($urandom_range(0, 3) != 0) && (o.size <= 3'd2))
         o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      if ($urandom_range(0, 11) == 0) o.addr = 32'h400 + 32'($urandom_range(0, 3) * 4);
      o.wdata = $urandom;
      return o;
   endfunction

   task automatic driveAddr(input bit valid, input op_t o);
      m_sel   = 1'b0;
      m_trans = 2'b00;
      m_addr  = o.addr;
      m_write = o.write;
      m_size  = o.size;
      if (valid) begin
         case (o.kind)
            K_XFER:  begin m_sel = 1'b1; m_trans = 2'b10; end
            K_IDLE:  begin m_sel = 1'b1; m_trans = 2'b00; end
            K_BUSY:  begin m_sel = 1'b1; m_trans = 2'b01; end
            default: begin m_sel = 1'b0; m_trans = 2'b10; end
         endcase
      end
   endtask

   // Pipelined master: the address slot advances into the data slot on every ready edge.
   task automatic applyStimulus();
      op_t ap, dp;
      bit  apv, dpv, rdy;
      int  guard;
      apv = 1'b0; dpv = 1'b0; guard = 0;
      ap = '{K_IDLE, 1'b0, 32'h0, 3'd0, 32'h0};
      dp = ap;
      if (ops.size() > 0) begin ap = ops.pop_front(); apv = 1'b1; end
      while ((apv || dpv) && (guard < GUARD)) begin
         driveAddr(apv, ap);
         m_wdata = dpv ? dp.wdata : 32'h0;
         @(negedge clk);
         rdy = cur_ready;
         @(posedge clk);
         if (rdy) begin
            if (apv && (ap.kind == K_XFER)) pushExpected(ap);
            dp  = ap;
            dpv = apv;
            apv = 1'b0;
            if (ops.size() > 0) begin ap = ops.pop_front(); apv = 1'b1; end
         end
         #1;
         guard++;
      end
      if (guard >= GUARD) begin
         total++;
         bad++;
         $display("[TB] FAIL drive_timeout: got stalled bus want completion within %0d cycles", GUARD);
         ops.delete();
      end
      driveAddr(1'b0, ap);
      m_wdata = 32'h0;
   endtask

   bit          mon_dp;
   int          mon_low;
   bit          mon_seen1, mon_seen0;
   exp_t        mon_e;

   // Monitor: every falling edge is either a stall, a data-phase completion or an idle cycle.
   initial begin
      mon_dp = 1'b0; mon_low = 0; mon_seen1 = 1'b0; mon_seen0 = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            mon_dp = 1'b0; mon_low = 0; mon_seen1 = 1'b0; mon_seen0 = 1'b0;
            continue;
         end
         if (mon_dp && !cur_ready) begin
            mon_low++;
            if (cur_resp) mon_seen1 = 1'b1; else mon_seen0 = 1'b1;
         end else begin
            if (mon_dp) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL sb_underflow: got completion want none queued at %0t", $time);
               end else begin
                  mon_e = exp_q.pop_front();
                  checkOutput("wait_cycles", 32'(mon_low), mon_e.err ? 32'd1 : (dut_sel ? 32'(WS1) : 32'd0));
                  if (mon_low > 0)
                     checkOutput("stall_resp", mon_seen1 ? (mon_seen0 ? 32'd2 : 32'd1) : 32'd0,
                                 mon_e.err ? 32'd1 : 32'd0);
                  checkOutput("done_resp", {31'd0, cur_resp}, {31'd0, mon_e.err});
                  checkOutput("rdata", cur_rdata, (mon_e.read && !mon_e.err) ? mon_e.rdata : 32'h0);
               end
            end else begin
               checkOutput("idle_ready", {31'd0, cur_ready}, 32'd1);
               checkOutput("idle_resp", {31'd0, cur_resp}, 32'd0);
               checkOutput("idle_rdata", cur_rdata, 32'h0);
            end
            mon_dp    = m_sel && m_trans[1] && cur_ready;
            mon_low   = 0;
            mon_seen1 = 1'b0;
            mon_seen0 = 1'b0;
         end
      end
   end

   initial begin
      op_t idle_op;
      total   = 0;
      bad     = 0;
      mon_en  = 1'b0;
      dut_sel = 1'b0;
      idle_op = '{K_IDLE, 1'b0, 32'h0, 3'd0, 32'h0};
      driveAddr(1'b0, idle_op);
      m_wdata = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready0", {31'd0, bus0.HREADYOUT}, 32'd1);
      checkOutput("reset_resp0", {31'd0, bus0.HRESP}, 32'd0);
      checkOutput("reset_rdata0", bus0.HRDATA, 32'h0);
      checkOutput("reset_ready1", {31'd0, bus1.HREADYOUT}, 32'd1);
      checkOutput("reset_resp1", {31'd0, bus1.HRESP}, 32'd0);
      checkOutput("reset_rdata1", bus1.HRDATA, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Zero-wait instance: fill the test region, then directed and random traffic.
      for (int i = 0; i < 16; i++) addOp(K_XFER, 1'b1, 32'(i * 4), 3'd2, $urandom);
      applyStimulus();
      addOp(K_XFER, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      addOp(K_XFER, 1'b0, 32'h10, 3'd2, 32'h0);
      addOp(K_XFER, 1'b1, 32'h10, 3'd2, 32'h11223344);
      addOp(K_XFER, 1'b1, 32'h13, 3'd0, 32'hAA5A5A5A);
      addOp(K_XFER, 1'b0, 32'h10, 3'd2, 32'h0);
      addOp(K_XFER, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
      addOp(K_XFER, 1'b0, 32'h400, 3'd2, 32'h0);
      addOp(K_XFER, 1'b1, 32'h02, 3'd2, 32'hFFFFFFFF);
      addOp(K_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
      addOp(K_XFER, 1'b0, 32'h00, 3'd2, 32'h0);
      addOp(K_BUSY, 1'b1, 32'h20, 3'd2, 32'h13579BDF);
      addOp(K_UNSEL, 1'b1, 32'h24, 3'd2, 32'h2468ACE0);
      addOp(K_XFER, 1'b0, 32'h20, 3'd2, 32'h0);
      addOp(K_XFER, 1'b0, 32'h24, 3'd2, 32'h0);
      applyStimulus();
      for (int i = 0; i < 120; i++) ops.push_back(randomOp());
      applyStimulus();

      // Three-wait instance.
      @(posedge clk);
      #1;
      dut_sel = 1'b1;
      for (int i = 0; i < 16; i++) addOp(K_XFER, 1'b1, 32'(i * 4), 3'd2, $urandom);
      addOp(K_XFER, 1'b0, 32'h04, 3'd2, 32'h0);
      applyStimulus();
      for (int i = 0; i < 60; i++) ops.push_back(randomOp());
      applyStimulus();

      // Reset pulse in the middle of a waited write: the write must be dropped.
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b1; m_addr = 32'h08; m_size = 3'd2;
      @(posedge clk);
      #1;
      m_sel = 1'b0; m_trans = 2'b00; m_wdata = 32'h12345678;
      @(negedge clk);
      checkOutput("stall_before_reset", {31'd0, bus1.HREADYOUT}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_ready", {31'd0, bus1.HREADYOUT}, 32'd1);
      checkOutput("async_rst_resp", {31'd0, bus1.HRESP}, 32'd0);
      checkOutput("async_rst_rdata", bus1.HRDATA, 32'h0);
      m_wdata = 32'h0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      addOp(K_XFER, 1'b0, 32'h08, 3'd2, 32'h0);
      addOp(K_XFER, 1'b1, 32'h08, 3'd2, 32'h0BADF00D);
      addOp(K_XFER, 1'b0, 32'h08, 3'd2, 32'h0);
      applyStimulus();

      repeat (3) @(posedge clk);
      #1;
      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
